pipe_step_ctrl: RTL and testbench

PIPE_STEP_CTRL -- requirements
Module: pipe_step_ctrl

---
 rtl/pipe_step_ctrl_pkg.sv | 16 +
 rtl/pipe_step_ctrl_hazard.sv | 16 +
 rtl/pipe_step_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_step_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_step_ctrl_pkg.sv
// Shared state encodings and constants for the pipeline run/step controller.
package pipe_step_ctrl_pkg;

  localparam int STATE_W      = 3;
  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_CNT_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pipe_step_ctrl_hazard.sv
// Load-use hazard detect: EX load writes a register the ID instruction reads.
module pipe_step_ctrl_hazard #(
  parameter int NB_ADDR = 5
) (
  input  logic               i_ex_mem_read,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  input  logic [NB_ADDR-1:0] i_id_rs,
  input  logic [NB_ADDR-1:0] i_id_rt,
  output logic               o_hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign o_hazard = i_ex_mem_read && (i_ex_rt != '0) &&
                    ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipe_step_ctrl.sv
// Run/step/drain controller for a 5-stage pipeline with stall/flush control.
// Define PIPE_STEP_CTRL_CYCLE_CNT_EN to build the saturating active-cycle counter.
module pipe_step_ctrl
  import pipe_step_ctrl_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_pause,
  input  logic               i_restart,
  input  logic               i_halt,
  input  logic               i_branch_taken,
  input  logic               i_ex_mem_read,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  input  logic [NB_ADDR-1:0] i_id_rs,
  input  logic [NB_ADDR-1:0] i_id_rt,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_id_ex_en,
  output logic               o_ex_mem_en,
  output logic               o_mem_wb_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_flush,
  output logic [STATE_W-1:0] o_state,
  output logic               o_done,
  output logic [NB_CNT-1:0]  o_cycle_count
);

  state_e                 state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
  logic                   hazard;
  logic                   active;
  logic                   halt_cond;

  pipe_step_ctrl_hazard #(.NB_ADDR(NB_ADDR)) u_hazard (
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt       (i_ex_rt),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .o_hazard      (hazard)
  );

  assign active    = (state_q == S_RUN) || (state_q == S_STEP);
  // A halt is only honoured once the ID instruction is really going to issue.
  assign halt_cond = active && i_halt && !hazard && !i_branch_taken;

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_run)       state_d = S_RUN;
        else if (i_step) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_cond) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (i_pause) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        drain_d = '0;
        state_d = halt_cond ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DRAIN_CNT_W'(1);
        end
      end
      S_DONE: begin
        if (i_restart) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (active) begin
      o_pc_en     = 1'b1;
      o_if_id_en  = 1'b1;
      o_id_ex_en  = 1'b1;
      o_ex_mem_en = 1'b1;
      o_mem_wb_en = 1'b1;
      if (i_branch_taken) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (hazard) begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_flush = 1'b1;
      end
    end else if (state_q == S_DRAIN) begin
      // Fetch is frozen and IF/ID bubbled so only in-flight work retires.
      o_if_id_en    = 1'b1;
      o_id_ex_en    = 1'b1;
      o_ex_mem_en   = 1'b1;
      o_mem_wb_en   = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = i_branch_taken;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign o_state = state_q;
  assign o_done  = (state_q == S_DONE);

`ifdef PIPE_STEP_CTRL_CYCLE_CNT_EN
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_DONE) && i_restart)
      cnt_d = '0;
    else if ((active || (state_q == S_DRAIN)) && (cnt_q != '1))
      cnt_d = cnt_q + NB_CNT'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_cycle_count = cnt_q;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed self-checking bench for pipe_step_ctrl; inputs change at negedge,
// outputs are checked 1 time unit later.
module tb_pipe_step_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst, i_run, i_step, i_pause, i_restart, i_halt, i_branch_taken;
  logic       i_ex_mem_read;
  logic [4:0] i_ex_rt, i_id_rs, i_id_rt;
  logic       o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
  logic       o_if_id_flush, o_id_ex_flush, o_done;
  logic [2:0] o_state;
  logic [31:0] o_cycle_count;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses;

  always #5 i_clk = ~i_clk;

  pipe_step_ctrl dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_run          (i_run),
    .i_step         (i_step),
    .i_pause        (i_pause),
    .i_restart      (i_restart),
    .i_halt         (i_halt),
    .i_branch_taken (i_branch_taken),
    .i_ex_mem_read  (i_ex_mem_read),
    .i_ex_rt        (i_ex_rt),
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .o_pc_en        (o_pc_en),
    .o_if_id_en     (o_if_id_en),
    .o_id_ex_en     (o_id_ex_en),
    .o_ex_mem_en    (o_ex_mem_en),
    .o_mem_wb_en    (o_mem_wb_en),
    .o_if_id_flush  (o_if_id_flush),
    .o_id_ex_flush  (o_id_ex_flush),
    .o_state        (o_state),
    .o_done         (o_done),
    .o_cycle_count  (o_cycle_count)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  logic [6:0] ctl;
  assign ctl = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
                o_if_id_flush, o_id_ex_flush};

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef PIPE_STEP_CTRL_CYCLE_CNT_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v * 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-14s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_run = 0; i_step = 0; i_pause = 0; i_restart = 0; i_halt = 0;
    i_branch_taken = 0; i_ex_mem_read = 0; i_ex_rt = 0; i_id_rs = 0; i_id_rt = 0;
  endtask

  // Advance one clock, return at the following negedge + 1.
  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    i_rst = 0;
    tick(); tick();
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_done",  32'(o_done), 32'd0);
    check("rst_ctl",   32'(ctl), 32'h00);
    check("rst_cnt",   o_cycle_count, 32'd0);

    // IDLE: run and step together, run wins
    i_rst = 1; i_run = 1; i_step = 1;
    tick(); clear_inputs();
    check("run_wins", 32'(o_state), 32'd1);
    check("run_ctl",  32'(ctl), 32'b1111100);
    tick();                                           // RUN cycle 1 done
    i_ex_mem_read = 1; i_ex_rt = 5; i_id_rs = 5; #1;
    check("stall_rs", 32'(ctl), 32'b0011101);
    tick();                                           // cycle 2
    i_ex_rt = 0; i_id_rs = 0; #1;
    check("rt0_nostall", 32'(ctl), 32'b1111100);
    tick();                                           // cycle 3
    i_ex_rt = 7; i_id_rs = 1; i_id_rt = 7; #1;
    check("stall_rt", 32'(ctl), 32'b0011101);
    tick();                                           // cycle 4
    i_ex_rt = 5; i_id_rs = 5; i_id_rt = 0; i_branch_taken = 1; #1;
    check("branch_ovr", 32'(ctl), 32'b1111111);
    tick();                                           // cycle 5
    clear_inputs(); i_pause = 1; #1;
    check("pause_ctl", 32'(ctl), 32'b1111100);
    tick(); clear_inputs();                           // cycle 6, back to IDLE
    check("pause_idle", 32'(o_state), 32'd0);
    check("idle_ctl",   32'(ctl), 32'h00);
    check("run_cnt",    o_cycle_count, exp_cnt(6));

    // STEP with halt while stalled: halt suppressed, back to IDLE
    i_step = 1;
    tick(); clear_inputs();
    i_halt = 1; i_ex_mem_read = 1; i_ex_rt = 3; i_id_rt = 3; #1;
    check("step_state", 32'(o_state), 32'd2);
    check("step_stall", 32'(ctl), 32'b0011101);
    tick(); clear_inputs();                           // cnt 7
    check("halt_blocked", 32'(o_state), 32'd0);

    // STEP with clean halt -> DRAIN x3 -> DONE
    i_step = 1;
    tick(); clear_inputs(); i_halt = 1; #1;
    tick(); clear_inputs();                           // cnt 8
    for (int d = 1; d <= 3; d++) begin
      i_pause = 1; i_step = 1; #1;                    // ignored in DRAIN
      check($sformatf("drain%0d_st", d), 32'(o_state), 32'd3);
      check($sformatf("drain%0d_ctl", d), 32'(ctl), 32'b0111110);
      tick(); clear_inputs();
    end                                               // cnt 11
    i_run = 1; #1;                                    // ignored in DONE
    check("done_state", 32'(o_state), 32'd4);
    check("done_flag",  32'(o_done), 32'd1);
    check("done_ctl",   32'(ctl), 32'h00);
    check("done_cnt",   o_cycle_count, exp_cnt(11));
    tick(); clear_inputs();
    check("done_hold", 32'(o_state), 32'd4);
    i_restart = 1;
    tick(); clear_inputs();
    check("restart_st",  32'(o_state), 32'd0);
    check("restart_dn",  32'(o_done), 32'd0);
    check("restart_cnt", o_cycle_count, exp_cnt(0));

    // Three single-step pulses
    pulses = 0;
    for (int s = 0; s < 3; s++) begin
      i_step = 1;
      tick(); clear_inputs();
      if (o_pc_en) pulses++;
      tick();
      if (o_pc_en) pulses++;
    end
    check("step_pulses", 32'(pulses), 32'd3);
    check("step_cnt", o_cycle_count, exp_cnt(3));

    // Reset during the 2nd DRAIN cycle
    i_step = 1;
    tick(); clear_inputs(); i_halt = 1; #1;
    tick(); clear_inputs();
    tick();
    i_rst = 0; #1;
    check("d2_state", 32'(o_state), 32'd3);
    tick();
    check("abort_st",  32'(o_state), 32'd0);
    check("abort_ctl", 32'(ctl), 32'h00);
    check("abort_cnt", o_cycle_count, 32'd0);
    i_rst = 1;
    tick();
    check("post_abort", 32'(ctl), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
